pmem_arbiter: RTL and testbench

//  Two-port arbiter between the instruction and data caches and the single cacheline_adaptor.

---
 rtl/pmem_arbiter_if.sv | 35 +++
 rtl/pmem_arbiter.sv | 98 +++++++++
 tb/tb_pmem_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_arbiter_if.sv
// Bus bundle between the two caches, the arbiter and the cacheline adaptor.
// slave is the arbiter's view; master is the surrounding caches and adaptor.
interface pmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic [ADDR_W-1:0] i_address;
  logic              i_read;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic [ADDR_W-1:0] d_address;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic [ADDR_W-1:0] pmem_address;
  logic              pmem_read;
  logic              pmem_write;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_address, i_read, d_address, d_read, d_write, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
  );

  modport master (
    output i_address, i_read, d_address, d_read, d_write, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter granting one cacheline transaction at a time from the
// icache or dcache to the single cacheline adaptor.
module pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic           clk,
  input  logic           reset_n,
  pmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic              last_d_reg, last_d_next;   // 1 when the most recent grant went to D
  logic              dir_wr_reg, dir_wr_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [LINE_W-1:0] wdata_reg, wdata_next;
  logic              req_i, req_d, pick_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      last_d_reg <= 1'b0;
      dir_wr_reg <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      last_d_reg <= last_d_next;
      dir_wr_reg <= dir_wr_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    last_d_next = last_d_reg;
    dir_wr_next = dir_wr_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    req_i       = bus.i_read;
    req_d       = bus.d_read | bus.d_write;
    // On a tie, D wins only if I had the last grant.
    pick_d      = req_d && (!req_i || !last_d_reg);
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    bus.i_resp     = 1'b0;
    bus.d_resp     = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (req_i || req_d) begin
          state_next  = pick_d ? GRANT_D : GRANT_I;
          last_d_next = pick_d;
          dir_wr_next = pick_d & bus.d_write;
          addr_next   = pick_d ? bus.d_address : bus.i_address;
          wdata_next  = bus.d_wdata;
        end
      end
      GRANT_I: begin
        bus.pmem_read  = ~dir_wr_reg;
        bus.pmem_write = dir_wr_reg;
        bus.i_resp     = bus.pmem_resp;
        if (bus.pmem_resp) state_next = IDLE;
      end
      GRANT_D: begin
        bus.pmem_read  = ~dir_wr_reg;
        bus.pmem_write = dir_wr_reg;
        bus.d_resp     = bus.pmem_resp;
        if (bus.pmem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.pmem_address = addr_reg;
  assign bus.pmem_wdata   = wdata_reg;
  assign bus.i_rdata      = bus.pmem_rdata;
  assign bus.d_rdata      = bus.pmem_rdata;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(bus.d_read && bus.d_write))
        else $error("d_read and d_write both high; treated as a write");
      assert (!(state_reg == IDLE && bus.pmem_resp))
        else $error("pmem_resp while idle is ignored");
    end
  end
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed scenarios with literal expectations, then
// random traffic against a transaction-level model and a memory model.
module tb_pmem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  pmem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory behind the adaptor; untouched lines read as the address repeated.
  logic [LW-1:0] mem [logic [AW-1:0]];

  function automatic logic [LW-1:0] mem_get(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return {8{a}};
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  // Transaction-level model: who owns the adaptor and what was latched.
  int            m_owner  = 0;     // 0 none, 1 icache, 2 dcache
  bit            m_wr     = 1'b0;
  logic [AW-1:0] m_addr   = '0;
  logic [LW-1:0] m_wdata  = '0;
  bit            m_d_next = 1'b1;  // D takes the next tie

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_owner = 0; m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_d_next = 1'b1;
    end else if (m_owner == 0) begin
      bit wi, wd;
      wi = bus.i_read;
      wd = bus.d_read | bus.d_write;
      if (wi || wd) begin
        if (wi && wd) m_owner = m_d_next ? 2 : 1;
        else          m_owner = wd ? 2 : 1;
        m_d_next = (m_owner == 1);
        m_wr     = (m_owner == 2) && bus.d_write;
        m_addr   = (m_owner == 2) ? bus.d_address : bus.i_address;
        m_wdata  = bus.d_wdata;
      end
    end else if (bus.pmem_resp) begin
      m_owner = 0;
    end
  end

  bit auto_ad = 1'b0;
  bit i_seen  = 1'b0;
  bit d_seen  = 1'b0;

  always @(negedge clk) begin
    #1;
    check("pmem_read",  bus.pmem_read,  LW'(m_owner != 0 && !m_wr));
    check("pmem_write", bus.pmem_write, LW'(m_owner != 0 && m_wr));
    check("i_resp", bus.i_resp, LW'(m_owner == 1 && bus.pmem_resp));
    check("d_resp", bus.d_resp, LW'(m_owner == 2 && bus.pmem_resp));
    if (m_owner != 0) check("pmem_address", bus.pmem_address, m_addr);
    if (m_owner != 0 && m_wr) check("pmem_wdata", bus.pmem_wdata, m_wdata);
    if (auto_ad && bus.pmem_resp && m_owner == 1) check("i_rdata", bus.i_rdata, mem_get(m_addr));
    if (auto_ad && bus.pmem_resp && m_owner == 2 && !m_wr) check("d_rdata", bus.d_rdata, mem_get(m_addr));
    i_seen = bus.i_resp;
    d_seen = bus.d_resp;
  end

  // Random-phase adaptor and cache behaviour, stepped once per falling edge.
  int ad_wait = 0;
  bit i_busy = 1'b0, d_busy = 1'b0;
  int i_age = 0, d_age = 0;
  int i_issued = 0, i_done = 0, d_issued = 0, d_done = 0;

  task automatic adaptor_step();
    if (bus.pmem_resp) begin
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = rand_line();
    end else if (bus.pmem_read || bus.pmem_write) begin
      if (ad_wait == 0) begin
        bus.pmem_resp = 1'b1;
        if (bus.pmem_write) mem[bus.pmem_address] = bus.pmem_wdata;
        else                bus.pmem_rdata = mem_get(bus.pmem_address);
        ad_wait = $urandom_range(0, 3);
      end else begin
        ad_wait--;
      end
    end
  endtask

  task automatic cache_i_step(input bit allow_new);
    if (i_busy) begin
      if (i_seen) begin
        check("i_latency_bounded", LW'(i_age <= 40), LW'(1));
        i_busy = 1'b0; bus.i_read = 1'b0; i_done++;
      end else if (++i_age > 200) begin
        check("i_timeout", LW'(i_age), LW'(0));
        i_busy = 1'b0; bus.i_read = 1'b0;
      end
    end else begin
      if (i_seen) check("i_spurious_resp", LW'(1), LW'(0));
      if (allow_new && $urandom_range(0, 2) == 0) begin
        i_busy = 1'b1; i_age = 0; i_issued++;
        bus.i_read = 1'b1;
        bus.i_address = AW'($urandom_range(0, 7)) << 5;
      end
    end
  endtask

  task automatic cache_d_step(input bit allow_new);
    if (d_busy) begin
      if (d_seen) begin
        check("d_latency_bounded", LW'(d_age <= 40), LW'(1));
        d_busy = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0; d_done++;
      end else if (++d_age > 200) begin
        check("d_timeout", LW'(d_age), LW'(0));
        d_busy = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
      end
    end else begin
      if (d_seen) check("d_spurious_resp", LW'(1), LW'(0));
      if (allow_new && $urandom_range(0, 2) == 0) begin
        bit wr;
        wr = ($urandom_range(0, 1) == 1);
        d_busy = 1'b1; d_age = 0; d_issued++;
        bus.d_read  = !wr;
        bus.d_write = wr;
        bus.d_address = AW'($urandom_range(0, 7)) << 5;
        bus.d_wdata = rand_line();
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] line_aa, line_55, zero_line, line_x;
    line_aa   = {8{32'hAAAA_AAAA}};
    line_55   = {8{32'h5555_5555}};
    zero_line = '0;
    line_x    = {8{32'h1234_5678}};

    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;

    // Reset values
    repeat (2) @(negedge clk);
    #2;
    check("rst_pmem_read",    bus.pmem_read,    LW'(0));
    check("rst_pmem_write",   bus.pmem_write,   LW'(0));
    check("rst_pmem_address", bus.pmem_address, LW'(0));
    check("rst_pmem_wdata",   bus.pmem_wdata,   zero_line);
    @(negedge clk); reset_n = 1'b1;

    // Single icache read
    @(negedge clk); bus.i_read = 1'b1; bus.i_address = 32'h60;
    @(negedge clk); #2;
    check("t1_pmem_read",    bus.pmem_read,    LW'(1));
    check("t1_pmem_address", bus.pmem_address, LW'(32'h60));
    @(negedge clk); bus.pmem_resp = 1'b1; bus.pmem_rdata = line_aa; #2;
    check("t1_i_resp",  bus.i_resp,  LW'(1));
    check("t1_i_rdata", bus.i_rdata, line_aa);
    check("t1_d_resp",  bus.d_resp,  LW'(0));
    @(negedge clk); bus.pmem_resp = 1'b0; bus.i_read = 1'b0; #2;
    check("t1_i_resp_pulse", bus.i_resp,    LW'(0));
    check("t1_idle_read",    bus.pmem_read, LW'(0));

    // Writeback with write data changing mid-grant
    @(negedge clk); bus.d_write = 1'b1; bus.d_address = 32'h1000; bus.d_wdata = line_55;
    @(negedge clk); #2;
    check("t2_pmem_write", bus.pmem_write, LW'(1));
    check("t2_pmem_read",  bus.pmem_read,  LW'(0));
    check("t2_pmem_wdata", bus.pmem_wdata, line_55);
    @(negedge clk); bus.d_wdata = '0; #2;
    check("t2_wdata_held", bus.pmem_wdata, line_55);
    @(negedge clk); bus.pmem_resp = 1'b1; #2;
    check("t2_d_resp", bus.d_resp, LW'(1));
    @(negedge clk); bus.pmem_resp = 1'b0; bus.d_write = 1'b0;

    // Simultaneous requests after reset: D first, then I, then D again
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    bus.i_read = 1'b1; bus.i_address = 32'h60;
    bus.d_read = 1'b1; bus.d_address = 32'h2000;
    @(negedge clk); #2;
    check("t3_first_is_d", bus.pmem_address, LW'(32'h2000));
    @(negedge clk); bus.pmem_resp = 1'b1; bus.pmem_rdata = line_x; #2;
    check("t3_d_resp", bus.d_resp, LW'(1));
    check("t3_i_wait", bus.i_resp, LW'(0));
    @(negedge clk); bus.pmem_resp = 1'b0; #2;
    check("t3_idle_gap", bus.pmem_read, LW'(0));
    @(negedge clk); #2;
    check("t3_second_is_i", bus.pmem_address, LW'(32'h60));
    @(negedge clk); bus.pmem_resp = 1'b1; #2;
    check("t3_i_resp", bus.i_resp, LW'(1));
    @(negedge clk); bus.pmem_resp = 1'b0; bus.i_read = 1'b0;
    @(negedge clk); #2;
    check("t3_third_is_d", bus.pmem_address, LW'(32'h2000));
    @(negedge clk); bus.pmem_resp = 1'b1;
    @(negedge clk); bus.pmem_resp = 1'b0; bus.d_read = 1'b0;

    // Asynchronous reset while D holds the grant
    @(negedge clk); bus.d_read = 1'b1; bus.d_address = 32'h3000;
    @(negedge clk); #2;
    check("t4_granted", bus.pmem_read, LW'(1));
    #1; reset_n = 1'b0; bus.d_read = 1'b0;
    #1;
    check("t4_async_read",  bus.pmem_read,  LW'(0));
    check("t4_async_write", bus.pmem_write, LW'(0));
    @(negedge clk); reset_n = 1'b1; bus.i_read = 1'b1; bus.i_address = 32'h80;
    @(posedge clk); #1;
    check("t4_fresh_grant", bus.pmem_read,    LW'(1));
    check("t4_fresh_addr",  bus.pmem_address, LW'(32'h80));
    @(negedge clk); bus.pmem_resp = 1'b1; #2;
    check("t4_i_resp", bus.i_resp, LW'(1));
    @(negedge clk); bus.pmem_resp = 1'b0; bus.i_read = 1'b0;
    @(negedge clk);

    // Random traffic against the memory model
    auto_ad = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      adaptor_step();
      cache_i_step(1'b1);
      cache_d_step(1'b1);
    end
    for (int c = 0; c < 300 && (i_busy || d_busy || bus.pmem_resp); c++) begin
      @(negedge clk);
      adaptor_step();
      cache_i_step(1'b0);
      cache_d_step(1'b0);
    end
    check("i_txn_count", LW'(i_done), LW'(i_issued));
    check("d_txn_count", LW'(d_done), LW'(d_issued));
    check("drained", LW'({i_busy, d_busy}), LW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
